// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle ALU: opcodes, flag bit positions and control states.
// Types only, no logic; used by both the top-level ALU and its multiply/divide unit.
package alu_pkg;

  typedef enum logic [4:0] {
    OP_LHI    = 5'd0,
    OP_ADD    = 5'd1,
    OP_SUB    = 5'd2,
    OP_AND    = 5'd3,
    OP_OR     = 5'd4,
    OP_XOR    = 5'd5,
    OP_SLL    = 5'd6,
    OP_SRL    = 5'd7,
    OP_SELZ   = 5'd8,
    OP_SELNZ  = 5'd9,
    OP_SEQ    = 5'd10,
    OP_SLE    = 5'd11,
    OP_SLT    = 5'd12,
    OP_SNE    = 5'd13,
    OP_SRA    = 5'd14,
    OP_ADD4   = 5'd15,
    OP_SELZ4  = 5'd16,
    OP_SELNZ4 = 5'd17,
    OP_MUL    = 5'd18,
    OP_MULHU  = 5'd19,
    OP_DIVU   = 5'd20,
    OP_REMU   = 5'd21
  } alu_op_t;

  // Bit positions inside flags = {illegal, div0, carry, zero}
  localparam int FLAG_ZERO    = 0;
  localparam int FLAG_CARRY   = 1;
  localparam int FLAG_DIV0    = 2;
  localparam int FLAG_ILLEGAL = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } alu_state_t;

  function automatic logic is_multicycle(alu_op_t op);
    return (op == OP_MUL) || (op == OP_MULHU) || (op == OP_DIVU) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/alu_muldiv.sv
// Iterative unsigned multiply/divide, one radix-2 step per cycle with the first step on start.
// done_o pulses WIDTH-1 cycles after start; no backpressure, the result must be taken on done_o.
module alu_muldiv
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  alu_op_t          op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic             div0_o
);

  localparam int CW = $clog2(WIDTH) + 1;

  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, b_q, b_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  alu_op_t          op_q, op_d;
  logic             busy_q, busy_d, div0_q, div0_d;

  logic [WIDTH-1:0] cur_hi, cur_lo, cur_b;
  alu_op_t          cur_op;
  logic [WIDTH:0]   sum, shifted, diff;
  logic             ge, step;

  assign done_o = busy_q && (cnt_q == CW'(WIDTH));
  assign div0_o = div0_q;

  // hi holds the partial product / remainder, lo the multiplier / quotient.
  always_comb begin
    cur_hi  = start_i ? '0   : hi_q;
    cur_lo  = start_i ? a_i  : lo_q;
    cur_b   = start_i ? b_i  : b_q;
    cur_op  = start_i ? op_i : op_q;
    step    = start_i || (busy_q && !done_o);
    sum     = {1'b0, cur_hi} + (cur_lo[0] ? {1'b0, cur_b} : '0);
    shifted = {cur_hi, cur_lo[WIDTH-1]};
    diff    = shifted - {1'b0, cur_b};
    ge      = shifted >= {1'b0, cur_b};

    hi_d   = hi_q;
    lo_d   = lo_q;
    b_d    = b_q;
    op_d   = op_q;
    div0_d = div0_q;
    cnt_d  = cnt_q;
    busy_d = start_i || (busy_q && !done_o);

    if (start_i) begin
      b_d    = b_i;
      op_d   = op_i;
      div0_d = ((op_i == OP_DIVU) || (op_i == OP_REMU)) && (b_i == '0);
      cnt_d  = CW'(1);
    end else if (step) begin
      cnt_d = cnt_q + CW'(1);
    end

    // A zero divisor needs no special case: every step subtracts, so the
    // quotient fills with ones and the dividend shifts through into hi.
    if (step) begin
      if ((cur_op == OP_MUL) || (cur_op == OP_MULHU)) begin
        hi_d = sum[WIDTH:1];
        lo_d = {sum[0], cur_lo[WIDTH-1:1]};
      end else begin
        hi_d = ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
        lo_d = {cur_lo[WIDTH-2:0], ge};
      end
    end
  end

  always_comb begin
    case (op_q)
      OP_MUL:  result_o = lo_q;
      OP_DIVU: result_o = lo_q;
      default: result_o = hi_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_q   <= '0;
      lo_q   <= '0;
      b_q    <= '0;
      op_q   <= OP_MUL;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      div0_q <= 1'b0;
    end else begin
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      b_q    <= b_d;
      op_q   <= op_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      div0_q <= div0_d;
    end
  end

endmodule

// File: rtl/alu_multicycle.sv
// Multi-cycle ALU: single-cycle ops complete in 1 cycle, mul/div in WIDTH+1 via alu_muldiv.
// Result held in DONE until out_ready; in_ready follows out_ready there for back-to-back issue.
module alu_multicycle
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  alu_op_t          op,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res,
  output logic [3:0]       flags
);

  alu_state_t       state_q, state_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [3:0]       flags_q, flags_d;

  logic [SHW-1:0]   shamt;
  logic [WIDTH:0]   add_w;
  logic [WIDTH-1:0] alu_res;
  logic             alu_carry, alu_illegal;

  logic             accept, md_start, md_done, md_div0;
  logic [WIDTH-1:0] md_result;

  assign shamt     = op2[SHW-1:0];
  assign out_valid = (state_q == ST_DONE);
  assign res       = res_q;
  assign flags     = flags_q;

  always_comb begin
    alu_res     = '0;
    alu_carry   = 1'b0;
    alu_illegal = 1'b0;
    add_w       = {1'b0, op1} + {1'b0, op2};
    case (op)
      OP_LHI:    alu_res = op2 << 16;
      OP_ADD:    begin alu_res = add_w[WIDTH-1:0]; alu_carry = add_w[WIDTH]; end
      OP_SUB:    begin alu_res = op1 - op2; alu_carry = (op1 < op2); end
      OP_AND:    alu_res = op1 & op2;
      OP_OR:     alu_res = op1 | op2;
      OP_XOR:    alu_res = op1 ^ op2;
      OP_SLL:    alu_res = op1 << shamt;
      OP_SRL:    alu_res = op1 >> shamt;
      OP_SELZ:   alu_res = (op1 == '0) ? op2 : '0;
      OP_SELNZ:  alu_res = (op1 != '0) ? op2 : '0;
      OP_SEQ:    alu_res = {{(WIDTH-1){1'b0}}, op1 == op2};
      OP_SLE:    alu_res = {{(WIDTH-1){1'b0}}, op1 <= op2};
      OP_SLT:    alu_res = {{(WIDTH-1){1'b0}}, op1 < op2};
      OP_SNE:    alu_res = {{(WIDTH-1){1'b0}}, op1 != op2};
      OP_SRA:    alu_res = $unsigned($signed(op1) >>> shamt);
      OP_ADD4:   alu_res = op1 + WIDTH'(4);
      OP_SELZ4:  alu_res = (op1 == '0) ? op2 : WIDTH'(4);
      OP_SELNZ4: alu_res = (op1 != '0) ? op2 : WIDTH'(4);
      OP_MUL, OP_MULHU, OP_DIVU, OP_REMU: alu_res = '0;
      default:   alu_illegal = 1'b1;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    res_d    = res_q;
    flags_d  = flags_q;
    md_start = 1'b0;
    case (state_q)
      ST_IDLE: in_ready = 1'b1;
      ST_DONE: in_ready = out_ready;
      default: in_ready = 1'b0;
    endcase
    accept = in_valid && in_ready;

    if (state_q == ST_BUSY) begin
      if (md_done) begin
        state_d             = ST_DONE;
        res_d               = md_result;
        flags_d             = '0;
        flags_d[FLAG_DIV0]  = md_div0;
        flags_d[FLAG_ZERO]  = (md_result == '0);
      end
    end else if (accept) begin
      if (is_multicycle(op)) begin
        state_d  = ST_BUSY;
        md_start = 1'b1;
      end else begin
        state_d               = ST_DONE;
        res_d                 = alu_res;
        flags_d               = '0;
        flags_d[FLAG_ILLEGAL] = alu_illegal;
        flags_d[FLAG_CARRY]   = alu_carry;
        flags_d[FLAG_ZERO]    = (alu_res == '0);
      end
    end else if ((state_q == ST_DONE) && out_ready) begin
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      res_q   <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      flags_q <= flags_d;
    end
  end

  alu_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk      (clk),
    .rst      (rst),
    .start_i  (md_start),
    .op_i     (op),
    .a_i      (op1),
    .b_i      (op2),
    .done_o   (md_done),
    .result_o (md_result),
    .div0_o   (md_div0)
  );

endmodule

// File: tb/tb_alu_multicycle.sv
// Scoreboard bench for alu_multicycle: directed corner cases, reset abort, then random traffic.
`timescale 1ns/1ps
module tb_alu_multicycle;
  import alu_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic         in_ready, out_valid;
  alu_op_t      op = OP_ADD;
  logic [W-1:0] op1 = '0, op2 = '0, res;
  logic [3:0]   flags;

  alu_multicycle #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .op1       (op1),
    .op2       (op2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .res       (res),
    .flags     (flags)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] res;
    logic [3:0]   flags;
    int           lat;
    int           acc;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  bit   or_rand = 1'b0;
  bit   or_force = 1'b1;
  bit   seen = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference behaviour straight from the operation definitions.
  function automatic exp_t model(input logic [4:0] code, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t           e;
    logic [2*W-1:0] prod;
    logic [W:0]     s;
    int             sh;
    e.res   = '0;
    e.flags = '0;
    e.lat   = 1;
    e.acc   = 0;
    sh      = int'(b[4:0]);
    prod    = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    case (code)
      5'd0:  e.res = b << 16;
      5'd1:  begin s = {1'b0, a} + {1'b0, b}; e.res = s[W-1:0]; e.flags[1] = s[W]; end
      5'd2:  begin e.res = a - b; e.flags[1] = (a < b); end
      5'd3:  e.res = a & b;
      5'd4:  e.res = a | b;
      5'd5:  e.res = a ^ b;
      5'd6:  e.res = a << sh;
      5'd7:  e.res = a >> sh;
      5'd8:  e.res = (a == 0) ? b : '0;
      5'd9:  e.res = (a != 0) ? b : '0;
      5'd10: e.res = W'(a == b);
      5'd11: e.res = W'(a <= b);
      5'd12: e.res = W'(a < b);
      5'd13: e.res = W'(a != b);
      5'd14: e.res = $unsigned($signed(a) >>> sh);
      5'd15: e.res = a + W'(4);
      5'd16: e.res = (a == 0) ? b : W'(4);
      5'd17: e.res = (a != 0) ? b : W'(4);
      5'd18: begin e.res = prod[W-1:0]; e.lat = W + 1; end
      5'd19: begin e.res = prod[2*W-1:W]; e.lat = W + 1; end
      5'd20: begin
        e.lat = W + 1;
        if (b == 0) begin e.res = '1; e.flags[2] = 1'b1; end
        else e.res = a / b;
      end
      5'd21: begin
        e.lat = W + 1;
        if (b == 0) begin e.res = a; e.flags[2] = 1'b1; end
        else e.res = a % b;
      end
      default: e.flags[3] = 1'b1;
    endcase
    e.flags[0] = (e.res == 0);
    return e;
  endfunction

  // Call at negedge+1: drives the request, reads in_ready at +2, records an accept.
  task automatic try_drive(input logic [4:0] code, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic v, output bit ok);
    exp_t e;
    in_valid = v;
    op       = alu_op_t'(code);
    op1      = a;
    op2      = b;
    #1;
    ok = v && in_ready;
    if (ok) begin
      e     = model(code, a, b);
      e.acc = cyc + 1;
      sb.push_back(e);
    end
  endtask

  task automatic issue(input logic [4:0] code, input logic [W-1:0] a, input logic [W-1:0] b,
                       output int waits);
    bit ok;
    ok    = 1'b0;
    waits = 0;
    while (!ok && waits < 100) begin
      @(negedge clk);
      #1;
      try_drive(code, a, b, 1'b1, ok);
      if (!ok) waits++;
    end
    check("issue_accepted", 64'(ok), 64'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (sb.size() != 0 && k < 200) begin
      @(negedge clk);
      #4;
      k++;
    end
    check("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  function automatic logic [W-1:0] rand_opnd();
    case ($urandom_range(0, 4))
      0:       return '0;
      1:       return '1;
      2:       return W'($urandom_range(0, 15));
      default: return W'($urandom);
    endcase
  endfunction

  initial forever begin
    @(negedge clk);
    #1;
    out_ready = or_rand ? ($urandom_range(0, 3) != 0) : or_force;
  end

  // Monitor: compares every cycle a result is presented, pops on transfer.
  initial forever begin
    @(negedge clk);
    #3;
    if (rst) begin
      seen = 1'b0;
    end else if (out_valid) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_output: res %0h flags %0h with nothing outstanding", res, flags);
      end else begin
        if (!seen) begin
          check("latency", 64'(cyc - sb[0].acc + 1), 64'(sb[0].lat));
          seen = 1'b1;
        end
        check("res", 64'(res), 64'(sb[0].res));
        check("flags", 64'(flags), 64'(sb[0].flags));
        if (out_ready) begin
          void'(sb.pop_front());
          seen = 1'b0;
        end
      end
    end else if (sb.size() != 0 && !seen && (cyc - sb[0].acc + 1) > sb[0].lat) begin
      n_chk++;
      n_fail++;
      seen = 1'b1;
      $display("FAIL result_timeout: no out_valid after %0d cycles, required %0d",
               cyc - sb[0].acc + 1, sb[0].lat);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit         ok;
    int         w;
    logic [4:0] code;

    repeat (2) @(negedge clk);
    #2;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_res", 64'(res), 64'd0);
    check("rst_flags", 64'(flags), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);

    // First accept on the first edge after release: ADD overflow.
    @(negedge clk);
    #1 rst = 1'b0;
    try_drive(5'd1, '1, W'(1), 1'b1, ok);
    check("first_edge_accept", 64'(ok), 64'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;

    issue(5'd14, 32'h8000_0000, W'(31), w);
    issue(5'd7,  32'h8000_0000, W'(31), w);
    issue(5'd19, '1, '1, w);
    issue(5'd18, '1, '1, w);
    issue(5'd20, W'(100), W'(7), w);
    issue(5'd21, W'(100), W'(7), w);
    issue(5'd20, W'(100), '0, w);
    issue(5'd21, W'(100), '0, w);
    issue(5'd0,  W'(5), 32'h0000_ABCD, w);
    issue(5'd25, W'(7), W'(9), w);
    issue(5'd11, W'(3), W'(3), w);
    drain();

    // Hold the SUB result with out_ready low, then issue back-to-back.
    or_force = 1'b0;
    issue(5'd2, W'(3), W'(5), w);
    repeat (5) begin
      @(negedge clk);
      #2;
      check("hold_in_ready", 64'(in_ready), 64'd0);
      check("hold_out_valid", 64'(out_valid), 64'd1);
    end
    or_force = 1'b1;
    issue(5'd5, 32'h0F0F_1234, 32'hFF00_00FF, w);
    check("b2b_waits", 64'(w), 64'd0);
    drain();

    // Reset in the middle of a divide abandons it.
    issue(5'd20, 32'h1234_5678, W'(3), w);
    repeat (10) @(negedge clk);
    #1 rst = 1'b1;
    sb.delete();
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_res", 64'(res), 64'd0);
    check("midrst_flags", 64'(flags), 64'd0);
    @(negedge clk);
    @(negedge clk);
    #1 rst = 1'b0;
    try_drive(5'd1, W'(2), W'(2), 1'b1, ok);
    check("post_rst_accept", 64'(ok), 64'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    drain();

    // Random traffic: operands change freely while the unit is busy.
    or_rand = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      #1;
      code = 5'($urandom_range(0, 31));
      try_drive(code, rand_opnd(), rand_opnd(), $urandom_range(0, 2) != 0, ok);
    end
    @(negedge clk);
    #1;
    in_valid = 1'b0;
    or_rand  = 1'b0;
    or_force = 1'b1;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_multicycle.md
ALU_MULTICYCLE -- requirements
Module: alu_multicycle

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, operand/result width (legal 8..64, power of two).
REQ-002 The block SHALL have parameter SHW, default $clog2(WIDTH), shift-amount width.
REQ-003 Port clk  in  1  sole clock; all state updates on rising edge.
REQ-004 Port rst  in  1  asynchronous, active-high reset.
REQ-005 Port in_valid  in  1  request present.
REQ-006 Port in_ready  out  1  block accepts request this cycle.
REQ-007 Port op  in  5  operation code (alu_pkg::alu_op_t).
REQ-008 Port op1, op2  in  WIDTH  operands.
REQ-009 Port out_valid  out  1  result held and valid.
REQ-010 Port out_ready  in  1  consumer takes result this cycle.
REQ-011 Port res  out  WIDTH  result.
REQ-012 Port flags  out  4  {illegal, div0, carry, zero}, qualified by out_valid.

Function
REQ-013 Transfer in: in_valid && in_ready at a rising edge; transfer out: out_valid && out_ready.
REQ-014 The FSM SHALL have states IDLE, BUSY, DONE.
REQ-015 in_ready SHALL be 1 in IDLE, 0 in BUSY, and equal out_ready in DONE (back-to-back issue).
REQ-016 Single-cycle ops (codes 0-17) SHALL go IDLE/DONE -> DONE with res registered on the accepting edge (latency 1).
REQ-017 Codes 0-17 SHALL keep the legacy meanings: 0 LHI (op2<<16, zero when WIDTH<=16), 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR, 6 SLL, 7 SRL, 8 op1==0?op2:0, 9 op1!=0?op2:0, 10 SEQ, 11 SLE, 12 SLT, 13 SNE, 14 SRA, 15 op1+4, 16 op1==0?op2:4, 17 op1!=0?op2:4.
REQ-018 Shift amount SHALL be op2[SHW-1:0] (full range, replacing the legacy 3-bit amount); SRA SHALL be arithmetic.
REQ-019 SLE/SLT SHALL compare unsigned; set-ops return 1 or 0 zero-extended.
REQ-020 carry SHALL be the WIDTH+1 bit of ADD, and the borrow (op1<op2) for SUB; 0 for all other ops.
REQ-021 zero SHALL be 1 iff res == 0, for every op.
REQ-022 Multi-cycle ops SHALL be 18 MUL (low half), 19 MULHU (high half, unsigned), 20 DIVU, 21 REMU.
REQ-023 Multi-cycle op accepted -> BUSY for exactly WIDTH cycles (one radix-2 step per cycle) -> DONE; out_valid asserts WIDTH+1 cycles after accept.
REQ-024 DIVU with op2==0 SHALL return all-ones; REMU SHALL return op1; both set div0=1; latency unchanged.
REQ-025 Codes 22-31 SHALL complete in 1 cycle with res=0, illegal=1, zero=1.
REQ-026 In DONE, res/flags SHALL hold stable until out_ready; DONE with out_ready and no new accept -> IDLE.
REQ-027 In BUSY, in_valid and operand changes SHALL be ignored; out_ready SHALL have no effect.
REQ-028 out_valid SHALL be 1 exactly in DONE.

Reset
REQ-029 rst asserted at any time, including mid-BUSY, SHALL immediately force IDLE, out_valid=0, res=0, flags=0, and abandon the iterative operation.
REQ-030 First accept SHALL be possible on the first rising edge after rst deasserts.

Structure
REQ-031 alu_pkg SHALL hold alu_op_t (5-bit enum, codes above), the flag-index constants, and the FSM state enum.
REQ-032 The iterative multiply/divide datapath SHALL be a sub-module alu_muldiv (start, op, operands in; done, result, div0 out), with the single-cycle datapath inline.

Verification
REQ-033 After reset, ADD op1=32'hFFFF_FFFF op2=1 -> next cycle out_valid=1, res=0, carry=1, zero=1.
REQ-034 SRA op1=32'h8000_0000 op2=31 -> res=32'hFFFF_FFFF; SRL same operands -> res=1.
REQ-035 MULHU op1=op2=32'hFFFF_FFFF -> out_valid exactly 33 cycles after accept, res=32'hFFFF_FFFE; MUL same -> res=1.
REQ-036 DIVU op1=100 op2=7 -> res=14; REMU -> res=2; DIVU op2=0 -> res=32'hFFFF_FFFF, div0=1.
REQ-037 Hold out_ready=0 for 5 cycles after SUB 3-5 -> res=32'hFFFF_FFFE stable, carry=1, in_ready=0; then back-to-back XOR accepted the same cycle out_ready rises.
REQ-038 Assert rst 10 cycles into DIVU -> out_valid=0 immediately; new ADD 2+2 after release -> res=4 at latency 1.
